// File: rtl/uart_rx_pkg.sv
// Shared types, limits and the parity helper for the UART receive controller.
package uart_rx_pkg;

  localparam int MIN_DATA_W   = 5;
  localparam int MIN_PRESCALE = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } uart_rx_state_e;

  // Expected parity bit for the low len bits of data; typ=1 selects odd parity.
  function automatic logic calc_parity(input logic [15:0] data, input logic [3:0] len,
                                       input logic typ);
    logic p;
    p = typ;
    for (int i = 0; i < 16; i++)
      if (i < int'(len)) p = p ^ data[i];
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversampled bit timer: edge counter, three mid-bit votes and majority decision.
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  rx,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_done,
  output logic                  vote_last,
  output logic                  sampled_bit
);

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] half;
  logic [2:0]            votes;
  logic                  third;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign half      = prescale >> 1;
  assign bit_done  = run && (edge_cnt == prescale - 1'b1);
  assign vote_last = run && (edge_cnt == half + 1'b1);

  // On the last vote cycle the third sample is taken straight from the line so
  // the stop-bit decision can be registered one cycle earlier.
  assign third       = vote_last ? rx : votes[2];
  assign sampled_bit = maj3(votes[0], votes[1], third);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      votes    <= '0;
    end else if (!run) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= bit_done ? '0 : edge_cnt + 1'b1;
      if (edge_cnt == half - 1'b1) votes[0] <= rx;
      if (edge_cnt == half)        votes[1] <= rx;
      if (edge_cnt == half + 1'b1) votes[2] <= rx;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, deserialiser and parity/stop/break checks.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic [3:0]            data_len,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  two_stop,
  output logic [DATA_W-1:0]     P_DATA,
  output logic                  data_valid,
  output logic                  par_error,
  output logic                  stop_error,
  output logic                  break_det,
  output logic                  busy
);

`ifdef UART_RX_BREAK_DETECT_EN
  localparam bit BREAK_EN = 1'b1;
`else
  localparam bit BREAK_EN = 1'b0;
`endif

  localparam logic [3:0] DW     = 4'(DATA_W);
  localparam logic [3:0] MIN_DW = 4'(MIN_DATA_W);

  uart_rx_state_e        state;
  logic                  armed;
  logic [3:0]            bit_cnt;
  logic [3:0]            len_q;
  logic [PRESCALE_W-1:0] pre_q;
  logic                  par_en_q, par_typ_q, two_stop_q;
  logic [DATA_W-1:0]     shreg;
  logic                  par_bad, stop_bad, ones;
  logic [3:0]            len_in;
  logic [DATA_W-1:0]     rx_word;
  logic                  bit_done, vote_last, sampled_bit;
  logic                  frame_end, stop0, is_break;

  assign busy      = (state != ST_IDLE);
  assign len_in    = (data_len < MIN_DW || data_len > DW) ? DW : data_len;
  assign rx_word   = shreg >> (DW - len_q);
  assign frame_end = vote_last && ((state == ST_STOP2) || (state == ST_STOP1 && !two_stop_q));
  assign stop0     = !sampled_bit || stop_bad;
  assign is_break  = BREAK_EN && !ones;

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .clk         (clk),
    .rst         (rst),
    .run         (busy),
    .rx          (RX_IN),
    .prescale    (pre_q),
    .bit_done    (bit_done),
    .vote_last   (vote_last),
    .sampled_bit (sampled_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      armed      <= 1'b1;
      bit_cnt    <= '0;
      len_q      <= '0;
      pre_q      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      two_stop_q <= 1'b0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      ones       <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_error  <= 1'b0;
      stop_error <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_error  <= 1'b0;
      stop_error <= 1'b0;
      break_det  <= 1'b0;
      if (frame_end) begin
        // Leave mid stop bit so a back-to-back start edge is never missed.
        state <= ST_IDLE;
        if (stop0 && is_break) begin
          break_det <= 1'b1;
          armed     <= 1'b0;
        end else if (stop0) begin
          stop_error <= 1'b1;
          armed      <= 1'b0;
        end else if (par_bad) begin
          par_error <= 1'b1;
        end else begin
          data_valid <= 1'b1;
          P_DATA     <= rx_word;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (!armed) begin
              if (RX_IN) armed <= 1'b1;
            end else if (!RX_IN) begin
              state      <= ST_START;
              pre_q      <= Prescale;
              len_q      <= len_in;
              par_en_q   <= PAR_EN;
              par_typ_q  <= PAR_TYP;
              two_stop_q <= two_stop;
              bit_cnt    <= '0;
              shreg      <= '0;
              par_bad    <= 1'b0;
              stop_bad   <= 1'b0;
              ones       <= 1'b0;
            end
          end
          ST_START: if (bit_done) state <= sampled_bit ? ST_IDLE : ST_DATA;
          ST_DATA: if (bit_done) begin
            shreg <= {sampled_bit, shreg[DATA_W-1:1]};
            ones  <= ones | sampled_bit;
            if (bit_cnt == len_q - 1'b1) state <= par_en_q ? ST_PARITY : ST_STOP1;
            else bit_cnt <= bit_cnt + 1'b1;
          end
          ST_PARITY: if (bit_done) begin
            par_bad <= sampled_bit != calc_parity(16'(rx_word), len_q, par_typ_q);
            ones    <= ones | sampled_bit;
            state   <= ST_STOP1;
          end
          ST_STOP1: if (two_stop_q && bit_done) begin
            stop_bad <= !sampled_bit;
            state    <= ST_STOP2;
          end
          ST_STOP2: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: serial frames in, expected strobes queued and popped.
module tb_uart_rx_ctrl;
  localparam int DW = 9;
  localparam int PW = 6;
  localparam logic [3:0] K_DV = 4'b0001, K_PAR = 4'b0010, K_STOP = 4'b0100, K_BRK = 4'b1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          RX_IN;
  logic [PW-1:0] Prescale;
  logic [3:0]    data_len;
  logic          PAR_EN, PAR_TYP, two_stop;
  logic [DW-1:0] P_DATA;
  logic          data_valid, par_error, stop_error, break_det, busy;

  typedef struct { logic [3:0] kind; logic [DW-1:0] data; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int dv_cyc = 0;

  uart_rx_ctrl #(.DATA_W(DW), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst), .RX_IN(RX_IN), .Prescale(Prescale), .data_len(data_len),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .two_stop(two_stop), .P_DATA(P_DATA),
    .data_valid(data_valid), .par_error(par_error), .stop_error(stop_error),
    .break_det(break_det), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_par(input logic [8:0] d, input int len, input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < len; i++) p = p ^ d[i];
    return p;
  endfunction

  // Scoreboard monitor: every strobe pops one expectation.
  always @(negedge clk) begin
    logic [3:0] s;
    exp_t e;
    s = {break_det, stop_error, par_error, data_valid};
    if (rst && s != 4'b0) begin
      if (sb.size() == 0) check("spurious_strobe", 32'(s), 32'h0);
      else begin
        e = sb.pop_front();
        check("strobe_kind", 32'(s), 32'(e.kind));
        if (e.kind == K_DV) check("p_data", 32'(P_DATA), 32'(e.data));
      end
      if (data_valid) begin
        dv_cyc = cyc;
        check("busy_at_dv", 32'(busy), 32'h0);
      end
    end
  end

  task automatic send_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] d, input int len, input bit par, input logic par_val,
                            input bit two, input logic s1, input logic s2, input int p,
                            output int start_cyc);
    start_cyc = cyc;
    send_bit(1'b0, p);
    for (int i = 0; i < len; i++) send_bit(d[i], p);
    if (par) send_bit(par_val, p);
    send_bit(s1, p);
    if (two) send_bit(s2, p);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    check("drain", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int st;
    rst = 1'b0; RX_IN = 1'b1; Prescale = 6'd16; data_len = 4'd8;
    PAR_EN = 1'b0; PAR_TYP = 1'b0; two_stop = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({P_DATA, data_valid, par_error, stop_error, break_det, busy}), 32'h0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5 at Prescale 16; strobe lands 154 clocks after the detection edge.
    sb.push_back('{K_DV, 9'h0A5});
    send_frame(9'h0A5, 8, 0, 1'b0, 0, 1'b1, 1'b1, 16, st);
    wait_drain(40);
    check("dv_latency", 32'(dv_cyc - st), 32'd155);

    // 8E1 0x3C with wrong parity bit.
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    sb.push_back('{K_PAR, 9'h0});
    send_frame(9'h03C, 8, 1, 1'b1, 0, 1'b1, 1'b1, 16, st);
    wait_drain(40);
    check("p_data_hold_par", 32'(P_DATA), 32'h0A5);

    // 7O1 0x13 good parity; config changed mid-frame must be ignored.
    data_len = 4'd7; PAR_TYP = 1'b1;
    sb.push_back('{K_DV, 9'h013});
    fork
      send_frame(9'h013, 7, 1, exp_par(9'h013, 7, 1'b1), 0, 1'b1, 1'b1, 16, st);
      begin
        repeat (40) @(negedge clk);
        Prescale = 6'd8; data_len = 4'd5; PAR_EN = 1'b0; PAR_TYP = 1'b0;
      end
    join
    wait_drain(40);

    // 7N2 0x55 with second stop low, line held low afterwards.
    Prescale = 6'd16; data_len = 4'd7; PAR_EN = 1'b0; two_stop = 1'b1;
    sb.push_back('{K_STOP, 9'h0});
    send_frame(9'h055, 7, 0, 1'b0, 1, 1'b1, 1'b0, 16, st);
    repeat (40) @(negedge clk);
    check("no_start_while_low", 32'(busy), 32'h0);
    check("p_data_hold_stop", 32'(P_DATA), 32'h013);
    RX_IN = 1'b1;
    wait_drain(10);
    repeat (4) @(negedge clk);

    // Glitch: three low clocks at Prescale 8.
    Prescale = 6'd8; data_len = 4'd8; two_stop = 1'b0;
    RX_IN = 1'b0;
    @(negedge clk);
    check("glitch_busy_rise", 32'(busy), 32'h1);
    repeat (2) @(negedge clk);
    RX_IN = 1'b1;
    repeat (5) @(negedge clk);
    check("glitch_busy_hold", 32'(busy), 32'h1);
    @(negedge clk);
    check("glitch_busy_fall", 32'(busy), 32'h0);
    repeat (4) @(negedge clk);

    // Back-to-back 9N1 frames at Prescale 32.
    Prescale = 6'd32; data_len = 4'd9;
    sb.push_back('{K_DV, 9'h1FF});
    sb.push_back('{K_DV, 9'h001});
    send_frame(9'h1FF, 9, 0, 1'b0, 0, 1'b1, 1'b1, 32, st);
    send_frame(9'h001, 9, 0, 1'b0, 0, 1'b1, 1'b1, 32, st);
    wait_drain(40);
    check("b2b_last_word", 32'(P_DATA), 32'h001);

    // Reset in the middle of the data bits.
    Prescale = 6'd16; data_len = 4'd8;
    send_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 16);
    check("busy_in_data", 32'(busy), 32'h1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_frame_reset", 32'({P_DATA, data_valid, par_error, stop_error, break_det, busy}), 32'h0);
    RX_IN = 1'b1;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_after_reset", 32'(busy), 32'h0);

    // All-zero 8N1 frame with low stop bit.
`ifdef UART_RX_BREAK_DETECT_EN
    sb.push_back('{K_BRK, 9'h0});
`else
    sb.push_back('{K_STOP, 9'h0});
`endif
    send_frame(9'h000, 8, 0, 1'b0, 0, 1'b0, 1'b0, 16, st);
    repeat (20) @(negedge clk);
    check("no_start_after_break", 32'(busy), 32'h0);
    RX_IN = 1'b1;
    wait_drain(10);
    repeat (4) @(negedge clk);

    // Re-armed line accepts a normal frame.
    sb.push_back('{K_DV, 9'h05A});
    send_frame(9'h05A, 8, 0, 1'b0, 0, 1'b1, 1'b1, 16, st);
    wait_drain(40);
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
